// File: rtl/vga_scan_timer.sv
// vga_scan_timer: pixel-rate divider, x/y scan counters, sync generation
// and registered RGB output stage for a VGA connector.
`timescale 1ns/1ps
module vga_scan_timer #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned DIV      = 4,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        p_tick,
   output logic        video_on,
   input  logic [11:0] pixel_in,
   input  logic        display_in,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL =
      H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL =
      V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DW = $clog2(DIV);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SE   =
      10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SE   =
      10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] r_div_cnt;
   logic [9:0]    r_x;
   logic [9:0]    r_y;
   logic [11:0]   r_rgb;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_frame_start;

   logic          w_p_tick;
   logic          w_video_on;
   logic          w_x_last;
   logic          w_y_last;
   logic          w_hs_act;
   logic          w_vs_act;
   logic [11:0]   w_pix;

   assign w_p_tick   = (r_div_cnt == DIV_LAST);
   assign w_video_on = (r_x < H_ACT) && (r_y < V_ACT);
   assign w_x_last   = (r_x == H_LAST);
   assign w_y_last   = (r_y == V_LAST);
   assign w_hs_act   = (r_x >= H_SS) && (r_x < H_SE);
   assign w_vs_act   = (r_y >= V_SS) && (r_y < V_SE);

   // Colour for the pixel at the current x/y, blanked outside active area
   always_comb begin
      w_pix = BG_COLOR;
      if (!w_video_on)
         w_pix = 12'h000;
      else if (display_in)
         w_pix = pixel_in;
   end

   // Clock divider producing one pixel tick every DIV clocks
   always_ff @(posedge clk) begin
      if (!reset)
         r_div_cnt <= '0;
      else if (w_p_tick)
         r_div_cnt <= '0;
      else
         r_div_cnt <= r_div_cnt + DW'(1);
   end

   // Scan counters advance on pixel ticks, wrapping line then frame
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_p_tick) begin
         if (w_x_last) begin
            r_x <= '0;
            r_y <= w_y_last ? '0 : r_y + 10'd1;
         end else begin
            r_x <= r_x + 10'd1;
         end
      end
   end

   // Output stage: one pixel of latency for colour and both syncs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rgb   <= 12'h000;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
      end else if (w_p_tick) begin
         r_rgb   <= w_pix;
         r_hsync <= !w_hs_act;
         r_vsync <= !w_vs_act;
      end
   end

   // Single-clock pulse when the scan wraps back to the frame origin
   always_ff @(posedge clk) begin
      if (!reset)
         r_frame_start <= 1'b0;
      else
         r_frame_start <= w_p_tick && w_x_last && w_y_last;
   end

   assign x           = r_x;
   assign y           = r_y;
   assign p_tick      = w_p_tick;
   assign video_on    = w_video_on;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign rgb         = r_rgb;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_timer.sv
// tb_vga_scan_timer: directed stimulus with a pixel scoreboard
// on a reduced 25x15 timing so whole frames stay short.
`timescale 1ns/1ps
module tb_vga_scan_timer;

   localparam int FRAME_CLKS = 25 * 15 * 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        p_tick;
   logic        video_on;
   logic [11:0] pixel_in = 12'h000;
   logic        display_in = 1'b0;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;
   logic        frame_start;

   vga_scan_timer #(
      .H_ACTIVE (16),
      .H_FP     (2),
      .H_SYNC   (4),
      .H_BP     (3),
      .V_ACTIVE (8),
      .V_FP     (2),
      .V_SYNC   (2),
      .V_BP     (3),
      .DIV      (4),
      .BG_COLOR (12'h05A)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .x           (x),
      .y           (y),
      .p_tick      (p_tick),
      .video_on    (video_on),
      .pixel_in    (pixel_in),
      .display_in  (display_in),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          px;
      int          py;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string nm, input int act,
                      input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int px, input int py,
                       input logic [11:0] c,
                       input logic hs, input logic vs);
      exp_t e;
      e.px = px;
      e.py = py;
      e.rgb = c;
      e.hs = hs;
      e.vs = vs;
      sb.push_back(e);
   endtask

   task automatic wait_xy(input int wx, input int wy,
                          input int lim);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(int'(x) == wx && int'(y) == wy)
                 && n < lim);
      if (!(int'(x) == wx && int'(y) == wy)) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_xy(%0d,%0d) timeout at (%0d,%0d)",
                  wx, wy, x, y);
      end
   endtask

   task automatic pulse_reset(input string nm);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk({nm, "_x"}, int'(x), 0);
      chk({nm, "_y"}, int'(y), 0);
      chk({nm, "_hsync"}, int'(hsync), 1);
      chk({nm, "_vsync"}, int'(vsync), 1);
      chk({nm, "_rgb"}, int'(rgb), 0);
      chk({nm, "_fs"}, int'(frame_start), 0);
      chk({nm, "_ptick"}, int'(p_tick), 0);
      chk({nm, "_von"}, int'(video_on), 1);
      reset = 1'b1;
   endtask

   // monitor: compares each finished pixel against the scoreboard
   int   cyc = 0;
   bit   pend = 0;
   int   px_s, py_s;
   int   hrun = 0, vrun = 0;
   bit   fs_valid = 0;
   int   fs_last = 0;
   bit   prev_fs = 0;
   int   fs_cnt = 0;
   exp_t e_m;

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         pend = 0;
         hrun = 0;
         vrun = 0;
         fs_valid = 0;
         prev_fs = 0;
      end else begin
         if (prev_fs)
            chk("fs_width", int'(frame_start), 0);
         prev_fs = frame_start;
         if (frame_start) begin
            fs_cnt++;
            chk("fs_x", int'(x), 0);
            chk("fs_y", int'(y), 0);
            if (fs_valid)
               chk("fs_period", cyc - fs_last, FRAME_CLKS);
            fs_valid = 1;
            fs_last = cyc;
         end
         if (pend) begin
            pend = 0;
            if (sb.size() > 0 && sb[0].px == px_s
                && sb[0].py == py_s) begin
               e_m = sb.pop_front();
               chk($sformatf("rgb(%0d,%0d)", px_s, py_s),
                   int'(rgb), int'(e_m.rgb));
               chk($sformatf("hs(%0d,%0d)", px_s, py_s),
                   int'(hsync), int'(e_m.hs));
               chk($sformatf("vs(%0d,%0d)", px_s, py_s),
                   int'(vsync), int'(e_m.vs));
            end
            if (!hsync) hrun++;
            else begin
               if (hrun > 0) chk("hsync_len", hrun, 4);
               hrun = 0;
            end
            if (!vsync) vrun++;
            else begin
               if (vrun > 0) chk("vsync_len", vrun, 50);
               vrun = 0;
            end
         end
         if (p_tick) begin
            pend = 1;
            px_s = int'(x);
            py_s = int'(y);
         end
      end
   end

   initial begin
      int e;
      // held reset
      repeat (5) @(posedge clk);
      #1;
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_rgb", int'(rgb), 0);
      chk("rst_fs", int'(frame_start), 0);
      chk("rst_ptick", int'(p_tick), 0);
      chk("rst_von", int'(video_on), 1);

      // line 0 boundaries
      push(0, 0, 12'h05A, 1, 1);
      push(15, 0, 12'h05A, 1, 1);
      push(16, 0, 12'h000, 1, 1);
      push(17, 0, 12'h000, 1, 1);
      push(18, 0, 12'h000, 0, 1);
      push(21, 0, 12'h000, 0, 1);
      push(22, 0, 12'h000, 1, 1);
      push(24, 0, 12'h000, 1, 1);

      reset = 1'b1;
      e = 0;
      do begin
         @(posedge clk);
         #1;
         e++;
         if (e <= 2) chk("tick_early", int'(p_tick), 0);
         if (e == 3) begin
            chk("tick_first", int'(p_tick), 1);
            chk("x_hold", int'(x), 0);
         end
         if (e == 4) begin
            chk("tick_clear", int'(p_tick), 0);
            chk("x_step", int'(x), 1);
            chk("fs_release", int'(frame_start), 0);
         end
      end while (int'(y) != 1 && e < 200);
      chk("line_clks", e, 100);
      chk("line_wrap_x", int'(x), 0);

      // sprite colour, background and blank override
      wait_xy(10, 3, 1000);
      display_in = 1'b1;
      pixel_in = 12'hF00;
      push(10, 3, 12'hF00, 1, 1);
      wait_xy(11, 3, 100);
      display_in = 1'b0;
      pixel_in = 12'h123;
      push(11, 3, 12'h05A, 1, 1);
      wait_xy(20, 3, 100);
      display_in = 1'b1;
      pixel_in = 12'hFFF;
      push(20, 3, 12'h000, 0, 1);
      wait_xy(21, 3, 100);
      display_in = 1'b0;
      pixel_in = 12'h000;

      // vertical boundaries
      push(0, 7, 12'h05A, 1, 1);
      push(15, 7, 12'h05A, 1, 1);
      push(16, 7, 12'h000, 1, 1);
      push(0, 8, 12'h000, 1, 1);
      push(24, 9, 12'h000, 1, 1);
      push(0, 10, 12'h000, 1, 0);
      push(18, 10, 12'h000, 0, 0);
      push(24, 11, 12'h000, 1, 0);
      push(0, 12, 12'h000, 1, 1);
      push(24, 14, 12'h000, 1, 1);

      e = 0;
      while (sb.size() > 0 && e < 2000) begin
         @(posedge clk);
         e++;
      end
      chk("sb_drain", sb.size(), 0);

      // frame periodicity
      e = 0;
      while (fs_cnt < 3 && e < 5000) begin
         @(posedge clk);
         e++;
      end
      chk("fs_count", fs_cnt, 3);

      // reset inside both sync pulses
      wait_xy(19, 10, 2000);
      chk("pre_hsync", int'(hsync), 0);
      chk("pre_vsync", int'(vsync), 0);
      pulse_reset("mid1");
      repeat (3) @(posedge clk);
      #1;
      chk("rs_tick", int'(p_tick), 1);
      chk("rs_x0", int'(x), 0);
      @(posedge clk);
      #1;
      chk("rs_x1", int'(x), 1);
      chk("rs_y", int'(y), 0);

      // reset while a sprite pixel is being shown
      wait_xy(5, 3, 2000);
      display_in = 1'b1;
      pixel_in = 12'hF00;
      wait_xy(6, 3, 100);
      chk("pre_rgb", int'(rgb), 12'hF00);
      display_in = 1'b0;
      pixel_in = 12'h000;
      pulse_reset("mid2");
      repeat (8) @(posedge clk);
      #1;
      chk("rs2_x", int'(x), 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
